// File: rtl/rgb2yuv_pkg.sv
// Shared imager constants: beat types, BT.601 full-range Q8 coefficients,
// rounding/offset constants and the converter latency.
package rgb2yuv_pkg;

   localparam int DTYPE_WIDTH = 4;

   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h4;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h5;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h8;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'h8;

   localparam logic signed [8:0] COEF_YR = 9'sd77;
   localparam logic signed [8:0] COEF_YG = 9'sd150;
   localparam logic signed [8:0] COEF_YB = 9'sd29;
   localparam logic signed [8:0] COEF_UR = -9'sd43;
   localparam logic signed [8:0] COEF_UG = -9'sd85;
   localparam logic signed [8:0] COEF_UB = 9'sd128;
   localparam logic signed [8:0] COEF_VR = 9'sd128;
   localparam logic signed [8:0] COEF_VG = -9'sd107;
   localparam logic signed [8:0] COEF_VB = -9'sd21;

   localparam int RND_CONST       = 128;
   localparam int CHROMA_OFFSET   = 128;
   localparam int RGB2YUV_LATENCY = 3;

   // Per-beat treatment chosen at stage 0 and carried with the data.
   typedef enum logic [1:0] {
      MODE_ZERO = 2'd0,
      MODE_CONV = 2'd1,
      MODE_BYP  = 2'd2
   } csc_mode_e;

endpackage

// File: rtl/csc_dot3.sv
// Two-stage signed three-term Q8 dot product with round-to-floor, offset and
// clamp to 0..255; also carries a bypass value and a zero/bypass/convert mode.
module csc_dot3
   import rgb2yuv_pkg::*;
#(
   parameter logic signed [8:0] C0     = 9'sd0,
   parameter logic signed [8:0] C1     = 9'sd0,
   parameter logic signed [8:0] C2     = 9'sd0,
   parameter int                OFFSET = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  csc_mode_e  mode_i,
   input  logic [7:0] x0_i,
   input  logic [7:0] x1_i,
   input  logic [7:0] x2_i,
   input  logic [7:0] byp_i,
   output logic [7:0] res_o
);

   logic signed [16:0] prod0_d, prod1_d, prod2_d;
   logic signed [16:0] prod0_p1_q, prod1_p1_q, prod2_p1_q;
   csc_mode_e          mode_p1_q;
   logic [7:0]         byp_p1_q;
   logic signed [18:0] sum_p2;
   logic [7:0]         res_d, res_p2_q;

   function automatic logic signed [16:0] mul_u8(input logic [7:0] x,
                                                 input logic signed [8:0] c);
      return 17'(signed'({1'b0, x})) * 17'(c);
   endfunction

   // Add half an LSB then arithmetic shift: floor((s + 128) / 256).
   function automatic logic signed [18:0] round_q8(input logic signed [18:0] s);
      logic signed [18:0] t;
      t = s + 19'(RND_CONST);
      return t >>> 8;
   endfunction

   function automatic logic [7:0] clamp_u8(input logic signed [18:0] v);
      if (v < 19'sd0)
         return 8'd0;
      else if (v > 19'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

   always_comb begin
      prod0_d = mul_u8(x0_i, C0);
      prod1_d = mul_u8(x1_i, C1);
      prod2_d = mul_u8(x2_i, C2);
   end

   // stage 1: products
   always_ff @(posedge clk) begin
      if (reset) begin
         prod0_p1_q <= '0;
         prod1_p1_q <= '0;
         prod2_p1_q <= '0;
         mode_p1_q  <= MODE_ZERO;
         byp_p1_q   <= '0;
      end else begin
         prod0_p1_q <= prod0_d;
         prod1_p1_q <= prod1_d;
         prod2_p1_q <= prod2_d;
         mode_p1_q  <= mode_i;
         byp_p1_q   <= byp_i;
      end
   end

   always_comb begin
      sum_p2 = 19'(prod0_p1_q) + 19'(prod1_p1_q) + 19'(prod2_p1_q);
      res_d  = 8'd0;
      case (mode_p1_q)
         MODE_CONV: res_d = clamp_u8(round_q8(sum_p2) + 19'(OFFSET));
         MODE_BYP:  res_d = byp_p1_q;
         default:   res_d = 8'd0;
      endcase
   end

   // stage 2: rounded, offset, clamped result
   always_ff @(posedge clk) begin
      if (reset)
         res_p2_q <= '0;
      else
         res_p2_q <= res_d;
   end

   assign res_o = res_p2_q;

endmodule

// File: rtl/rgb2yuv.sv
// RGB to full-range BT.601 YUV converter, fixed 3-cycle latency for every beat.
// Holds the input register, the per-beat mode decision and the sideband delay.
module rgb2yuv
   import rgb2yuv_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   dvi,
   input  logic [DTYPE_WIDTH-1:0] dtypei,
   input  logic [15:0]            meta_datai,
   input  logic [PIXEL_WIDTH-1:0] ri,
   input  logic [PIXEL_WIDTH-1:0] gi,
   input  logic [PIXEL_WIDTH-1:0] bi,
   output logic                   dvo,
   output logic [DTYPE_WIDTH-1:0] dtypeo,
   output logic [15:0]            meta_datao,
   output logic [7:0]             yo,
   output logic [7:0]             uo,
   output logic [7:0]             vo
);

   logic                   dv_p0_q, dv_p1_q, dv_p2_q;
   logic [DTYPE_WIDTH-1:0] dtype_p0_q, dtype_p1_q, dtype_p2_q;
   logic [15:0]            meta_p0_q, meta_p1_q, meta_p2_q;
   logic                   en_p0_q;
   logic [7:0]             r8_p0_q, g8_p0_q, b8_p0_q;
   csc_mode_e              mode_p0;

   // stage 0: input register, components truncated to their top 8 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         dv_p0_q    <= 1'b0;
         dtype_p0_q <= '0;
         meta_p0_q  <= '0;
         en_p0_q    <= 1'b0;
         r8_p0_q    <= '0;
         g8_p0_q    <= '0;
         b8_p0_q    <= '0;
      end else begin
         dv_p0_q    <= dvi;
         dtype_p0_q <= dtypei;
         meta_p0_q  <= meta_datai;
         en_p0_q    <= enable;
         r8_p0_q    <= ri[PIXEL_WIDTH-1 -: 8];
         g8_p0_q    <= gi[PIXEL_WIDTH-1 -: 8];
         b8_p0_q    <= bi[PIXEL_WIDTH-1 -: 8];
      end
   end

   always_comb begin
      mode_p0 = MODE_ZERO;
      if ((dtype_p0_q & DTYPE_PIXEL_MASK) != '0)
         mode_p0 = en_p0_q ? MODE_CONV : MODE_BYP;
   end

   // stages 1-2: sideband delay matching the dot-product pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         dv_p1_q    <= 1'b0;
         dtype_p1_q <= '0;
         meta_p1_q  <= '0;
         dv_p2_q    <= 1'b0;
         dtype_p2_q <= '0;
         meta_p2_q  <= '0;
      end else begin
         dv_p1_q    <= dv_p0_q;
         dtype_p1_q <= dtype_p0_q;
         meta_p1_q  <= meta_p0_q;
         dv_p2_q    <= dv_p1_q;
         dtype_p2_q <= dtype_p1_q;
         meta_p2_q  <= meta_p1_q;
      end
   end

   csc_dot3 #(.C0(COEF_YR), .C1(COEF_YG), .C2(COEF_YB), .OFFSET(0)) u_dot_y (
      .clk(clk), .reset(reset), .mode_i(mode_p0),
      .x0_i(r8_p0_q), .x1_i(g8_p0_q), .x2_i(b8_p0_q), .byp_i(r8_p0_q),
      .res_o(yo)
   );

   csc_dot3 #(.C0(COEF_UR), .C1(COEF_UG), .C2(COEF_UB), .OFFSET(CHROMA_OFFSET)) u_dot_u (
      .clk(clk), .reset(reset), .mode_i(mode_p0),
      .x0_i(r8_p0_q), .x1_i(g8_p0_q), .x2_i(b8_p0_q), .byp_i(g8_p0_q),
      .res_o(uo)
   );

   csc_dot3 #(.C0(COEF_VR), .C1(COEF_VG), .C2(COEF_VB), .OFFSET(CHROMA_OFFSET)) u_dot_v (
      .clk(clk), .reset(reset), .mode_i(mode_p0),
      .x0_i(r8_p0_q), .x1_i(g8_p0_q), .x2_i(b8_p0_q), .byp_i(b8_p0_q),
      .res_o(vo)
   );

   assign dvo        = dv_p2_q;
   assign dtypeo     = dtype_p2_q;
   assign meta_datao = meta_p2_q;

endmodule

// File: tb/tb_rgb2yuv.sv
// Scoreboard bench for rgb2yuv: directed beats push hand-computed results,
// per-instance monitors pop and compare whenever dvo is high.
module tb_rgb2yuv;
   import rgb2yuv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, enable, dvi, dvi10;
   logic [3:0]  dtypei;
   logic [15:0] meta_datai;
   logic [7:0]  ri, gi, bi;
   logic [9:0]  ri10, gi10, bi10;

   logic        dvo8, dvo10;
   logic [3:0]  dtypeo8, dtypeo10;
   logic [15:0] meta8, meta10;
   logic [7:0]  yo8, uo8, vo8, yo10, uo10, vo10;

   int cyc = 0;
   int checks = 0;
   int passes = 0;

   typedef struct {
      int          due;
      logic [3:0]  dt;
      logic [15:0] md;
      logic [7:0]  y, u, v;
   } exp_t;

   exp_t q8[$];
   exp_t q10[$];

   rgb2yuv #(.PIXEL_WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .dtypei(dtypei),
      .meta_datai(meta_datai), .ri(ri), .gi(gi), .bi(bi),
      .dvo(dvo8), .dtypeo(dtypeo8), .meta_datao(meta8),
      .yo(yo8), .uo(uo8), .vo(vo8)
   );

   rgb2yuv #(.PIXEL_WIDTH(10)) dut10 (
      .clk(clk), .reset(reset), .enable(enable), .dvi(dvi10), .dtypei(dtypei),
      .meta_datai(meta_datai), .ri(ri10), .gi(gi10), .bi(bi10),
      .dvo(dvo10), .dtypeo(dtypeo10), .meta_datao(meta10),
      .yo(yo10), .uo(uo10), .vo(vo10)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (dvo8) begin
         if (q8.size() == 0)
            chk("dvo8_unexpected", dvo8, 0);
         else begin
            e = q8.pop_front();
            chk("lat8", cyc, e.due);
            chk("dtype8", dtypeo8, e.dt);
            chk("meta8", meta8, e.md);
            chk("y8", yo8, e.y);
            chk("u8", uo8, e.u);
            chk("v8", vo8, e.v);
         end
      end else if (q8.size() > 0 && q8[0].due <= cyc) begin
         chk("dvo8_missing", dvo8, 1);
         void'(q8.pop_front());
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (dvo10) begin
         if (q10.size() == 0)
            chk("dvo10_unexpected", dvo10, 0);
         else begin
            e = q10.pop_front();
            chk("lat10", cyc, e.due);
            chk("dtype10", dtypeo10, e.dt);
            chk("y10", yo10, e.y);
            chk("u10", uo10, e.u);
            chk("v10", vo10, e.v);
         end
      end else if (q10.size() > 0 && q10[0].due <= cyc) begin
         chk("dvo10_missing", dvo10, 1);
         void'(q10.pop_front());
      end
   end

   task automatic beat(input logic v, input logic [3:0] dt, input logic [15:0] md,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic en, input logic push,
                       input logic [7:0] ey, input logic [7:0] eu, input logic [7:0] ev);
      exp_t e;
      @(posedge clk); #1;
      dvi = v; dvi10 = 1'b0; dtypei = dt; meta_datai = md;
      ri = r; gi = g; bi = b; enable = en;
      if (v && push) begin
         e.due = cyc + RGB2YUV_LATENCY; e.dt = dt; e.md = md;
         e.y = ey; e.u = eu; e.v = ev;
         q8.push_back(e);
      end
   endtask

   task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic en, input logic [7:0] ey, input logic [7:0] eu,
                      input logic [7:0] ev);
      beat(1'b1, DTYPE_PIXEL, 16'h0, r, g, b, en, 1'b1, ey, eu, ev);
   endtask

   task automatic beat10(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                         input logic [7:0] ey, input logic [7:0] eu, input logic [7:0] ev);
      exp_t e;
      @(posedge clk); #1;
      dvi = 1'b0; dvi10 = 1'b1; dtypei = DTYPE_PIXEL; meta_datai = 16'h0;
      ri10 = r; gi10 = g; bi10 = b; enable = 1'b1;
      e.due = cyc + RGB2YUV_LATENCY; e.dt = DTYPE_PIXEL; e.md = 16'h0;
      e.y = ey; e.u = eu; e.v = ev;
      q10.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         dvi = 1'b0; dvi10 = 1'b0; dtypei = DTYPE_PIXEL;
         ri = 8'hA5; gi = 8'h5A; bi = 8'h33;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dvo"}, {31'd0, dvo8}, 0);
      chk({tag, "_dtype"}, {28'd0, dtypeo8}, 0);
      chk({tag, "_meta"}, {16'd0, meta8}, 0);
      chk({tag, "_yuv"}, {8'd0, yo8, uo8, vo8}, 0);
      chk({tag, "_dvo10"}, {31'd0, dvo10}, 0);
      chk({tag, "_yuv10"}, {8'd0, yo10, uo10, vo10}, 0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; dvi = 1'b0; dvi10 = 1'b0;
      dtypei = DTYPE_HEADER; meta_datai = 16'hFFFF;
      ri = 8'hFF; gi = 8'hFF; bi = 8'hFF;
      ri10 = 10'h3FF; gi10 = 10'h3FF; bi10 = 10'h3FF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // White, black, pure red/blue (upper clamp), yellow (U reaches 1)
      pix(8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd128, 8'd128);
      pix(8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   8'd128, 8'd128);
      pix(8'd255, 8'd0,   8'd0,   1'b1, 8'd77,  8'd85,  8'd255);
      pix(8'd0,   8'd0,   8'd255, 1'b1, 8'd29,  8'd255, 8'd107);
      pix(8'd255, 8'd255, 8'd0,   1'b1, 8'd226, 8'd1,   8'd149);
      idle(5);

      // 10-bit instance: truncation to top 8 bits
      beat10(10'd1023, 10'd1023, 10'd1023, 8'd255, 8'd128, 8'd128);
      beat10(10'd3,    10'd3,    10'd3,    8'd0,   8'd128, 8'd128);
      beat10(10'd1023, 10'd0,    10'd0,    8'd77,  8'd85,  8'd255);
      idle(5);

      // Framed sequence with headers, a dvi=0 gap and non-pixel zeroing
      beat(1'b1, DTYPE_FRAME_START, 16'h0001, 8'd200, 8'd200, 8'd200, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      beat(1'b1, DTYPE_HEADER,      16'h1234, 8'd200, 8'd200, 8'd200, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      beat(1'b1, DTYPE_HEADER,      16'hBEEF, 8'd17,  8'd99,  8'd250, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      beat(1'b1, DTYPE_ROW_START,   16'h0002, 8'd1,   8'd2,   8'd3,   1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      pix(8'd100, 8'd150, 8'd200, 1'b1, 8'd141, 8'd161, 8'd99);
      pix(8'd0,   8'd255, 8'd0,   1'b1, 8'd149, 8'd43,  8'd21);
      beat(1'b0, DTYPE_PIXEL, 16'h0, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      pix(8'd255, 8'd255, 8'd0,   1'b1, 8'd226, 8'd1,   8'd149);
      pix(8'd128, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128);
      beat(1'b1, DTYPE_ROW_END,     16'h0003, 8'd9,   8'd9,   8'd9,   1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      beat(1'b1, DTYPE_FRAME_END,   16'h0004, 8'd9,   8'd9,   8'd9,   1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
      idle(5);

      // Bypass toggle between two pixels; non-pixel beat in bypass still zero
      pix(8'd10, 8'd20, 8'd30, 1'b1, 8'd18, 8'd135, 8'd122);
      pix(8'd40, 8'd50, 8'd60, 1'b0, 8'd40, 8'd50,  8'd60);
      beat(1'b1, DTYPE_HEADER, 16'h5555, 8'd40, 8'd50, 8'd60, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      pix(8'd255, 8'd0, 8'd0, 1'b1, 8'd77, 8'd85, 8'd255);
      idle(5);

      // Reset for one cycle with three beats in flight
      beat(1'b1, DTYPE_PIXEL,  16'h0, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      beat(1'b1, DTYPE_HEADER, 16'hCAFE, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
      dvi = 1'b1; dtypei = DTYPE_PIXEL; meta_datai = 16'h7777; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; dvi = 1'b0; dtypei = '0; meta_datai = '0;
      ri = '0; gi = '0; bi = '0;
      @(negedge clk);
      chk_all_zero("midreset");
      pix(8'd0, 8'd0, 8'd255, 1'b1, 8'd29, 8'd255, 8'd107);
      idle(6);

      chk("q8_drained", q8.size(), 0);
      chk("q10_drained", q10.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rgb2yuv.md
# rgb2yuv

Pipelined colour-space converter from RGB to full-range BT.601 (JFIF) YUV with unsigned, offset U/V. It sits directly upstream of the YUV 4:2:0 packer and drives that block's `dvi`/`dtypei`/`meta_datai`/`yi`/`ui`/`vi` inputs. All beats (pixels, headers, frame and row markers) pass through with one fixed latency, so the stream framing is unchanged. `meta_data` is forwarded untouched, so raw mode downstream keeps working.

## Interface
- `PIXEL_WIDTH`, 8: width of the input R/G/B components; must be ≥ 8.
- `clk` input 1: the single clock; every flop is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: 1 = convert; 0 = bypass, where Y/U/V = R/G/B reduced to 8 bits.
- `dvi` input 1: input beat valid.
- `dtypei` input `DTYPE_WIDTH`: beat type.
- `meta_datai` input 16: header/raw data, forwarded unchanged.
- `ri`, `gi`, `bi` input `PIXEL_WIDTH` each: colour components.
- `dvo` output 1: output beat valid.
- `dtypeo` output `DTYPE_WIDTH`: delayed `dtypei`.
- `meta_datao` output 16: delayed `meta_datai`.
- `yo`, `uo`, `vo` output 8 each: unsigned results; U/V are offset by 128.

## Operation
- **No backpressure.** The pipeline advances every cycle and the valid bit travels with the data.
- **Stage 0 (input register).** Register `dvi`, `dtypei`, `meta_datai` and `enable`. Reduce each colour input to 8 bits as `c8 = c >> (PIXEL_WIDTH-8)`, truncating with no rounding.
- **Stage 1 (products).** Form nine signed products of each 8b unsigned component and a 9b signed coefficient, each 17b signed. Coefficients are Q8:
  - Y: 77, 150, 29
  - U: −43, −85, 128
  - V: 128, −107, −21
- **Stage 2 (sum, round, clamp).**
  - Sum each channel's three products into 19b signed.
  - Add 128, then arithmetic-shift right by 8, giving floor division.
  - Add 128 to U and V only.
  - Clamp to 0..255.
  - Register the results onto `yo`/`uo`/`vo`.
- **Bypass.** When the stage-0 registered `enable` is 0, the beat outputs `yo=r8`, `uo=g8`, `vo=b8` with the same latency.
  - `enable` is sampled per beat, so a toggle mid-frame affects only beats entering after the toggle.
- **Non-pixel beats.** Any beat where `dtype & DTYPE_PIXEL_MASK == 0` outputs `yo=uo=vo=0`, with `dtypeo`/`meta_datao` forwarded.
- **Beats with `dvi=0`.** These propagate `dvo=0`; the data outputs are don't-care and are not checked.
- **Framing.** The block performs no framing checks and adds or drops no beats.

## Timing
- **Latency.** Exactly 3 cycles: a beat presented with `dvi=1` at edge N appears with `dvo=1` after edge N+3. Throughput is 1 beat per cycle.
- **Alignment.** `dtypeo`, `meta_datao`, `yo`, `uo` and `vo` are always aligned with the same beat's `dvo`.
- **Reset values.** All outputs and all pipeline registers reset to 0: `dvo=0`, `dtypeo=0`, `meta_datao=0`, `yo=uo=vo=0`.
- **Reset mid-frame.** Reset clears every in-flight beat. No partial beat emerges afterwards. The first post-reset beat appears 3 cycles after it is presented.
- **Arithmetic boundaries.**
  - Y never exceeds 255 before clamping.
  - U/V can reach 256 before clamping, which is clamped to 255.
  - The minimum U/V is 1, so the lower clamp exists only for safety.

## Structure
- **Shared package.** The nine Q8 coefficients, the rounding constant (128), the chroma offset (128) and the 3-cycle latency live in the shared imager constants package next to `dtypes.v`. The downstream packer and the testbenches reference `RGB2YUV_LATENCY` from there.
- **Sub-module.** One sub-module, `csc_dot3`: a 2-stage signed three-term dot product with round, offset and clamp, parameterised by its three coefficients and an offset. It is instantiated three times, and the top level holds stage 0 and the sideband delay line.

## Test plan
- **White.** R=G=B=255, `enable=1`, `PIXEL_WIDTH=8` → Y=255, U=128, V=128 exactly 3 cycles later with `dvo=1`. Black (0,0,0) → 0, 128, 128.
- **Pure red and pure blue** (both exercise the upper clamp).
  - (255,0,0) → Y=77, U=85, V=255.
  - (0,0,255) → Y=29, U=255, V=107.
- **10-bit input.** `PIXEL_WIDTH=10`, R=G=B=1023 → Y=255, U=128, V=128. R=G=B=3 → Y=0, U=128, V=128 (truncated to 8b).
- **Non-pixel beats and gaps.** FRAME_START, then HEADER beats with `meta_datai` 0x1234 and 0xBEEF, then ROW_START, 4 pixels with a `dvi=0` gap, ROW_END, FRAME_END.
  - Identical `dtypeo`/`meta_datao` sequence appears, each beat shifted by exactly 3 cycles.
  - Non-pixel beats output Y/U/V = 0.
- **Bypass toggle.** Drop `enable` to 0 between two pixels (10,20,30) and (40,50,60) → the first is converted, the second is output as Y=40, U=50, V=60.
- **Reset mid-frame.** Assert `reset` for 1 cycle while 3 beats are in flight → `dvo` stays 0 for those beats and all outputs read 0. The next pixel emerges 3 cycles after it is presented.
